pulse_sync_mc: RTL and testbench
================================

Name: pulse_sync_mc

Overview:
- Multi-channel clock-domain-crossing pulse synchroniser, clksrc → clkdest, NUM_CH independent channels.
- Each channel uses a toggle request/acknowledge handshake with a configurable synchroniser depth.
- A per-channel pending counter queues source pulses that arrive while a transfer is in flight, so back-to-back pulses are not lost. Saturation beyond the counter's range is flagged.
- Used wherever event strobes (IRQs, counters, triggers) cross between unrelated clock domains.

Parameters:
- NUM_CH, 4: number of independent pulse channels (≥1).
- SYNC_STAGES, 2: flops per synchroniser chain, applied in both directions (≥2).
- PEND_W, 3: pending-counter width. Queue depth is 2^PEND_W−1 pulses beyond the one in flight (≥1).

Ports:
- clksrc  in  1  source clock
- rstb_clksrc  in  1  source-domain reset
- clkdest  in  1  destination clock
- rstb_clkdest  in  1  destination-domain reset, asynchronous assert, active-low
- pulse_clksrc  in  NUM_CH  single-cycle (or level-per-cycle) event strobes, clksrc domain
- ovf_clr_clksrc  in  NUM_CH  write-one-to-clear for ovf_clksrc bits
- busy_clksrc  out  NUM_CH  channel has a transfer in flight or pulses pending
- ovf_clksrc  out  NUM_CH  sticky: a pulse was dropped on a saturated queue
- pulse_clkdest  out  NUM_CH  registered single-cycle pulses, clkdest domain

Interface decision: reset rstb_clksrc, asynchronous, active-low; clock clksrc.

Behaviour:
- Reset values: all source-side state = 0 (req toggle, pending, busy, ovf, ack sync chain). All dest-side state = 0 (req sync chain, edge-detect flop, pulse_clkdest).
- Source side, per channel, registered on clksrc:
  - inflight = req ^ ack_sync.
  - Each clksrc cycle with pulse_clksrc[i]=1 counts as one event. A held level counts one event per cycle.
  - Event while inflight=0 and pending=0: req toggles at the next edge.
  - Event while inflight=1: pending += 1.
  - Event while pending = 2^PEND_W−1: event dropped, pending unchanged, ovf set.
  - inflight=0 and pending>0: req toggles and pending −= 1 in the same edge.
  - Simultaneous event and toggle-from-pending: pending unchanged, req toggles.
  - Simultaneous event and ack completion with pending=0: req toggles immediately, pending stays 0.
- busy_clksrc = inflight | (pending≠0), registered.
- ovf: set has priority over ovf_clr in the same cycle.
- Dest side:
  - req passes through a SYNC_STAGES chain into an edge-detect flop.
  - pulse_clkdest = registered (sync_out ^ edge_q).
  - Latency from req toggle to pulse_clkdest high: SYNC_STAGES+1 clkdest edges, +1 edge of sync uncertainty.
  - Pulse width is exactly one clkdest cycle per transfer.
- Ack path:
  - sync_out (dest-side level) returns through a SYNC_STAGES chain on clksrc as ack_sync.
  - Round-trip per transfer ≈ (SYNC_STAGES+1)·Tdest + SYNC_STAGES·Tsrc.
  - Sustained throughput is one pulse per round-trip; excess pulses queue.
- Clock ratio: any ratio supported. Correctness does not depend on the relation between clksrc and clkdest.
- Reset mid-operation:
  - Source reset alone clears the queue and ovf; in-flight and queued pulses are lost.
  - Dest reset alone while req=1 yields exactly one spurious pulse after release.
  - System requirement: both resets are asserted together. Split reset is not a supported use.
- No combinational path from any input to any output. All CDC crossings are single-bit toggles.

Decomposition:
- Shared package: PULSE_SYNC_MIN_STAGES=2 and a localparam function for the pending maximum (2^PEND_W−1).
- Sub-module sync_cell: parametrised SYNC_STAGES single-bit synchroniser with async active-low reset. Instantiated twice per channel.
- Optionally pulse_sync_ch: one channel. The top level is a generate loop over NUM_CH.

Test Plan:
1. Single pulse on ch0, SYNC_STAGES=2, clksrc 100 MHz, clkdest 37 MHz → one pulse_clkdest[0] high for 1 clkdest cycle, 3–4 clkdest edges after the req toggle. busy_clksrc[0] deasserts after the round-trip.
2. Burst of 5 back-to-back pulse_clksrc[1] cycles, PEND_W=3 → exactly 5 pulse_clkdest[1] pulses, pending peaks at 4, ovf_clksrc[1]=0.
3. Burst of 10 back-to-back pulses, PEND_W=3 → exactly 8 dest pulses (1 in flight + 7 queued), ovf_clksrc=1 and sticky. ovf_clr_clksrc pulse → ovf=0. A simultaneous set+clear keeps ovf=1.
4. New event in the same clksrc cycle as ack completion with pending=0 → req toggles that edge, no pending increment, two dest pulses total.
5. All 4 channels pulsed in the same cycle, clkdest 3× faster than clksrc → each channel gives exactly 1 pulse, with no cross-channel interaction.
6. Both resets asserted mid-burst (pending=3), then released → all outputs 0, no dest pulse after release, and a subsequent single pulse is transferred normally.

Source files
------------

// File: rtl/pulse_sync_mc_pkg.sv
// Shared constants and helpers for the multi-channel pulse synchroniser.
//   PULSE_SYNC_MIN_STAGES : smallest synchroniser depth the cells will build
//   pend_max()            : largest pending-queue count for a given counter width
package pulse_sync_mc_pkg;

  localparam int unsigned PULSE_SYNC_MIN_STAGES = 2;

  // Queue depth beyond the transfer in flight: 2^pend_w - 1.
  function automatic int unsigned pend_max(input int unsigned pend_w);
    return (32'd1 << pend_w) - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_sync_mc_sync_cell.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
//   clk_i  : destination clock of the crossing
//   rst_ni : asynchronous active-low reset, clears the whole chain
//   d_i    : level from the foreign clock domain
//   q_o    : synchronised level, Stages flops after d_i
module pulse_sync_mc_sync_cell
  import pulse_sync_mc_pkg::*;
#(
  parameter int unsigned Stages = PULSE_SYNC_MIN_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  // Never build a chain shorter than the metastability minimum.
  localparam int unsigned Depth =
      (Stages < PULSE_SYNC_MIN_STAGES) ? PULSE_SYNC_MIN_STAGES : Stages;

  logic [Depth-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Depth-2:0], d_i};
    end
  end

  assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/pulse_sync_mc.sv
// Multi-channel toggle-handshake pulse synchroniser, clksrc -> clkdest.
// Each channel queues source events in a pending counter while a transfer
// is in flight; events arriving on a full queue are dropped and flagged.
//   clksrc / rstb_clksrc   : source clock, async active-low reset
//   clkdest / rstb_clkdest : destination clock, async active-low reset
//   pulse_clksrc           : per-channel event strobes (one event per high cycle)
//   ovf_clr_clksrc         : write-one-to-clear for ovf_clksrc
//   busy_clksrc            : transfer in flight or events pending (registered)
//   ovf_clksrc             : sticky dropped-event flag
//   pulse_clkdest          : registered single-cycle pulses in clkdest domain
module pulse_sync_mc
  import pulse_sync_mc_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PEND_W      = 3
) (
  input  logic              clksrc,
  input  logic              rstb_clksrc,
  input  logic              clkdest,
  input  logic              rstb_clkdest,
  input  logic [NUM_CH-1:0] pulse_clksrc,
  input  logic [NUM_CH-1:0] ovf_clr_clksrc,
  output logic [NUM_CH-1:0] busy_clksrc,
  output logic [NUM_CH-1:0] ovf_clksrc,
  output logic [NUM_CH-1:0] pulse_clkdest
);

  localparam logic [PEND_W-1:0] PendMax = PEND_W'(pend_max(PEND_W));
  localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic              req_q, req_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              ovf_set;
    logic              ack_sync;
    logic              inflight;
    logic              ev;
    logic              sync_out;
    logic              edge_q;
    logic              dpulse_q;

    assign ev       = pulse_clksrc[i];
    assign inflight = req_q ^ ack_sync;

    always_comb begin
      req_d   = req_q;
      pend_d  = pend_q;
      ovf_set = 1'b0;
      if (!inflight) begin
        if (pend_q != '0) begin
          // Launch a queued pulse; a coincident event takes the freed slot.
          req_d = ~req_q;
          if (!ev) begin
            pend_d = pend_q - PendOne;
          end
        end else if (ev) begin
          req_d = ~req_q;
        end
      end else if (ev) begin
        if (pend_q == PendMax) begin
          ovf_set = 1'b1;
        end else begin
          pend_d = pend_q + PendOne;
        end
      end
      ovf_d  = ovf_set | (ovf_q & ~ovf_clr_clksrc[i]);
      busy_d = (req_d ^ ack_sync) | (pend_d != '0);
    end

    always_ff @(posedge clksrc or negedge rstb_clksrc) begin
      if (!rstb_clksrc) begin
        req_q  <= 1'b0;
        pend_q <= '0;
        busy_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        req_q  <= req_d;
        pend_q <= pend_d;
        busy_q <= busy_d;
        ovf_q  <= ovf_d;
      end
    end

    // Request level into the destination domain.
    pulse_sync_mc_sync_cell #(
      .Stages (SYNC_STAGES)
    ) u_req_sync (
      .clk_i  (clkdest),
      .rst_ni (rstb_clkdest),
      .d_i    (req_q),
      .q_o    (sync_out)
    );

    always_ff @(posedge clkdest or negedge rstb_clkdest) begin
      if (!rstb_clkdest) begin
        edge_q   <= 1'b0;
        dpulse_q <= 1'b0;
      end else begin
        edge_q   <= sync_out;
        dpulse_q <= sync_out ^ edge_q;
      end
    end

    // Acknowledge: the destination's view of req returns to the source.
    pulse_sync_mc_sync_cell #(
      .Stages (SYNC_STAGES)
    ) u_ack_sync (
      .clk_i  (clksrc),
      .rst_ni (rstb_clksrc),
      .d_i    (sync_out),
      .q_o    (ack_sync)
    );

    assign busy_clksrc[i]   = busy_q;
    assign ovf_clksrc[i]    = ovf_q;
    assign pulse_clkdest[i] = dpulse_q;
  end

endmodule

// File: tb/tb_pulse_sync_mc.sv
`timescale 1ns/1ps
module tb_pulse_sync_mc;

  logic       clksrc         = 1'b0;
  logic       clkdest        = 1'b0;
  logic       rstb_clksrc    = 1'b1;
  logic       rstb_clkdest   = 1'b1;
  logic [3:0] pulse_clksrc   = '0;
  logic [3:0] ovf_clr_clksrc = '0;
  logic [3:0] busy_clksrc;
  logic [3:0] ovf_clksrc;
  logic [3:0] pulse_clkdest;

  real dhalf = 13.5;

  int checks    = 0;
  int failures  = 0;
  int dcnt      = 0;
  int width_err = 0;
  int pcnt [4];
  logic [3:0] prev_p = '0;

  pulse_sync_mc #(
    .NUM_CH      (4),
    .SYNC_STAGES (2),
    .PEND_W      (3)
  ) dut (
    .clksrc         (clksrc),
    .rstb_clksrc    (rstb_clksrc),
    .clkdest        (clkdest),
    .rstb_clkdest   (rstb_clkdest),
    .pulse_clksrc   (pulse_clksrc),
    .ovf_clr_clksrc (ovf_clr_clksrc),
    .busy_clksrc    (busy_clksrc),
    .ovf_clksrc     (ovf_clksrc),
    .pulse_clkdest  (pulse_clkdest)
  );

  initial forever #5 clksrc = ~clksrc;
  initial forever #(dhalf) clkdest = ~clkdest;

  always @(posedge clkdest) dcnt <= dcnt + 1;

  // Dest-side pulse counting and width monitoring, sampled mid-cycle.
  always @(negedge clkdest) begin
    for (int i = 0; i < 4; i++) begin
      if (pulse_clkdest[i]) pcnt[i] <= pcnt[i] + 1;
    end
    width_err <= width_err + $countones(pulse_clkdest & prev_p);
    prev_p    <= pulse_clkdest;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // n back-to-back event cycles on mask; clr_last is driven on the final cycle.
  task automatic burst(input logic [3:0] mask, input int n, input logic [3:0] clr_last);
    for (int k = 0; k < n; k++) begin
      @(negedge clksrc);
      pulse_clksrc = mask;
      if (k == n - 1) ovf_clr_clksrc = clr_last;
    end
    @(negedge clksrc);
    pulse_clksrc   = '0;
    ovf_clr_clksrc = '0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy_clksrc != '0 && k < 3000) begin
      @(negedge clksrc);
      k++;
    end
    check({tag, "_idle"}, int'(busy_clksrc), 0);
    repeat (4) @(negedge clkdest);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, lat, k, base;
    int b [4];

    #1;
    rstb_clksrc  = 1'b0;
    rstb_clkdest = 1'b0;
    repeat (3) @(negedge clksrc);
    check("rst_busy",  int'(busy_clksrc),   0);
    check("rst_ovf",   int'(ovf_clksrc),    0);
    check("rst_pulse", int'(pulse_clkdest), 0);
    rstb_clksrc  = 1'b1;
    rstb_clkdest = 1'b1;
    repeat (5) @(negedge clksrc);

    // T1: single pulse, latency 3..4 dest edges after the req toggle edge.
    @(negedge clksrc);
    pulse_clksrc = 4'b0001;
    @(posedge clksrc);
    #0.01 d0 = dcnt;
    @(negedge clksrc);
    pulse_clksrc = '0;
    check("t1_busy", int'(busy_clksrc[0]), 1);
    k = 0;
    while (!pulse_clkdest[0] && k < 100) begin
      @(negedge clkdest);
      k++;
    end
    lat = dcnt - d0;
    check("t1_seen", int'(pulse_clkdest[0]), 1);
    check("t1_lat_in_3_4", int'(lat >= 3 && lat <= 4), 1);
    wait_idle("t1");
    check("t1_cnt", pcnt[0], 1);

    // T2: 5-event burst fits in the queue.
    base = pcnt[1];
    burst(4'b0010, 5, 4'b0000);
    wait_idle("t2");
    check("t2_cnt", pcnt[1] - base, 5);
    check("t2_ovf", int'(ovf_clksrc), 0);

    // T3: slow dest so the round trip far exceeds the 10-event burst.
    dhalf = 50.0;
    repeat (30) @(negedge clksrc);
    base = pcnt[2];
    burst(4'b0100, 10, 4'b0000);
    check("t3_ovf_set", int'(ovf_clksrc[2]), 1);
    check("t3_ovf_others", int'(ovf_clksrc & 4'b1011), 0);
    wait_idle("t3a");
    check("t3_cnt", pcnt[2] - base, 8);
    check("t3_ovf_sticky", int'(ovf_clksrc[2]), 1);
    @(negedge clksrc);
    ovf_clr_clksrc = 4'b0100;
    @(negedge clksrc);
    ovf_clr_clksrc = '0;
    check("t3_ovf_clr", int'(ovf_clksrc[2]), 0);
    base = pcnt[2];
    burst(4'b0100, 10, 4'b0100);
    check("t3_set_beats_clr", int'(ovf_clksrc[2]), 1);
    wait_idle("t3b");
    check("t3_cnt2", pcnt[2] - base, 8);
    @(negedge clksrc);
    ovf_clr_clksrc = 4'b0100;
    @(negedge clksrc);
    ovf_clr_clksrc = '0;
    check("t3_ovf_clr2", int'(ovf_clksrc[2]), 0);

    // T4: second event swept across the ack-completion cycle.
    dhalf = 13.5;
    repeat (10) @(negedge clksrc);
    for (int d = 1; d <= 12; d++) begin
      base = pcnt[0];
      burst(4'b0001, 1, 4'b0000);
      repeat (d - 1) @(negedge clksrc);
      burst(4'b0001, 1, 4'b0000);
      wait_idle($sformatf("t4_d%0d", d));
      check($sformatf("t4_cnt_d%0d", d), pcnt[0] - base, 2);
    end

    // T5: all channels at once, dest 3x faster.
    dhalf = 5.0 / 3.0;
    repeat (10) @(negedge clksrc);
    for (int i = 0; i < 4; i++) b[i] = pcnt[i];
    burst(4'b1111, 1, 4'b0000);
    wait_idle("t5");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_cnt_ch%0d", i), pcnt[i] - b[i], 1);
    end

    // T6: both resets mid-burst with three events queued.
    dhalf = 50.0;
    repeat (30) @(negedge clksrc);
    base = pcnt[3];
    burst(4'b1000, 4, 4'b0000);
    @(negedge clksrc);
    rstb_clksrc  = 1'b0;
    rstb_clkdest = 1'b0;
    #1;
    check("t6_rst_busy",  int'(busy_clksrc),   0);
    check("t6_rst_ovf",   int'(ovf_clksrc),    0);
    check("t6_rst_pulse", int'(pulse_clkdest), 0);
    repeat (3) @(negedge clksrc);
    rstb_clksrc  = 1'b1;
    rstb_clkdest = 1'b1;
    repeat (60) @(negedge clksrc);
    check("t6_post_busy", int'(busy_clksrc), 0);
    check("t6_no_pulse", pcnt[3] - base, 0);
    burst(4'b1000, 1, 4'b0000);
    wait_idle("t6");
    check("t6_cnt_after", pcnt[3] - base, 1);

    check("width_one_cycle", width_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
